// File: rtl/spi_slave_core.sv
// Mode-0 SPI slave: oversamples cs_b/sclk/mosi in the clk domain and moves words through rx/tx valid/ready handshakes.
// Optional build macro SPI_SLAVE_CORE_LSB_FIRST_EN selects LSB-first receive and transmit (MSB-first otherwise).
module spi_slave_core #(
  parameter int unsigned        DATA_W      = 8,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]  DEFAULT_TX  = '1
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              cs_b,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LOAD_NEXT
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q, flush_q;
  logic                   cs_dly_q, sclk_dly_q;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                   armed_q, armed_d;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      rxsh_q, rxsh_d, txsh_q, txsh_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   miso_q, miso_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic                   frame_err_q, frame_err_d;
  logic                   load_c, word_done_c;

  logic [DATA_W-1:0]      tx_word, tx_shifted, rx_shifted;
  logic                   tx_first, tx_next;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      flush_q     <= '0;
      cs_dly_q    <= 1'b1;
      sclk_dly_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_b};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      cs_dly_q    <= cs_s;
      sclk_dly_q  <= sclk_s;
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_rise   = cs_s & ~cs_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  // The preset cs_b=1 would fake a falling edge if the pin is already low after reset,
  // so frames only start once a genuine high level has come through the synchronizer.
  assign armed_d = armed_q | (flush_q[SYNC_STAGES-1] & cs_s);

  assign tx_word = tx_valid ? tx_data : DEFAULT_TX;

`ifdef SPI_SLAVE_CORE_LSB_FIRST_EN
  assign tx_first   = tx_word[0];
  assign tx_shifted = {1'b0, txsh_q[DATA_W-1:1]};
  assign tx_next    = tx_shifted[0];
  assign rx_shifted = {mosi_s, rxsh_q[DATA_W-1:1]};
`else
  assign tx_first   = tx_word[DATA_W-1];
  assign tx_shifted = {txsh_q[DATA_W-2:0], 1'b0};
  assign tx_next    = tx_shifted[DATA_W-1];
  assign rx_shifted = {rxsh_q[DATA_W-2:0], mosi_s};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rxsh_d      = rxsh_q;
    txsh_d      = txsh_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    load_c      = 1'b0;
    word_done_c = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    // A cs_b rise overrides every sclk event seen in the same cycle.
    if (state_q != S_IDLE && cs_rise) begin
      state_d     = S_IDLE;
      miso_d      = 1'b0;
      frame_err_d = (state_q == S_SHIFT) && (cnt_q != '0);
      cnt_d       = '0;
      rxsh_d      = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          miso_d = 1'b0;
          if (cs_fall && armed_q) state_d = S_LOAD;
        end
        S_LOAD: load_c = 1'b1;
        S_SHIFT: begin
          if (sclk_rise) begin
            rxsh_d = rx_shifted;
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
              cnt_d       = '0;
              word_done_c = 1'b1;
              state_d     = S_LOAD_NEXT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (sclk_fall) begin
            txsh_d = tx_shifted;
            miso_d = tx_next;
          end
        end
        S_LOAD_NEXT: if (sclk_fall) load_c = 1'b1;
        default: state_d = S_IDLE;
      endcase

      if (load_c) begin
        txsh_d  = tx_word;
        miso_d  = tx_first;
        cnt_d   = '0;
        state_d = S_SHIFT;
      end

      if (word_done_c) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = rx_shifted;
          rx_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rxsh_q      <= '0;
      txsh_q      <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rxsh_q      <= rxsh_d;
      txsh_q      <= txsh_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
    end
  end

  assign miso      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_ready  = load_c & tx_valid;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
- Synthesizable, clocked SPI slave (mode 0: CPOL=0, CPHA=0) that receives the serial stream produced by spi_master and returns a response stream on miso.
- Oversamples cs_b, sclk and mosi in the system clock domain.
- Exposes parallel receive and transmit words through valid/ready handshakes to downstream logic.
- Replaces the behavioural spi_slave in RTL-level benches and designs.

Parameters:
- DATA_W, 8, word length in bits per transfer unit (2..32).
- SYNC_STAGES, 2, synchronizer flops on cs_b, sclk, mosi (2..3).
- DEFAULT_TX, 8'hFF (DATA_W wide), word shifted out when no tx word is offered at a load point.

Ports:
- clk  input  1  system clock; frequency must be at least 8x sclk.
- rst_b  input  1  synchronous reset, active-low.
- cs_b  input  1  SPI chip select, active-low, asynchronous to clk.
- sclk  input  1  SPI clock, asynchronous to clk.
- mosi  input  1  SPI data from master.
- miso  output  1  SPI data to master.
- rx_data  output  DATA_W  last received word.
- rx_valid  output  1  rx_data holds an unconsumed word.
- rx_ready  input  1  consumer accepts rx_data.
- tx_data  input  DATA_W  word to shift out.
- tx_valid  input  1  tx_data is offered.
- tx_ready  output  1  one-cycle pulse: tx_data captured this cycle.
- busy  output  1  frame in progress.
- overrun  output  1  sticky: a received word was dropped.
- frame_err  output  1  one-cycle pulse: cs_b deasserted mid-word.

Behaviour:
- Reset (rst_b low at a clk rising edge):
  - miso, rx_data, rx_valid, tx_ready, busy, overrun and frame_err all go to 0.
  - Synchronizers preset: cs_b=1, sclk=0, mosi=0.
  - FSM goes to IDLE; the bit counter and both shift registers clear.
- Reset mid-frame: the frame is abandoned. After reset releases, the FSM stays in IDLE until it has seen synchronized cs_b high, then low, so a partial frame is never decoded.
- Edge detection: rise/fall of synchronized sclk and fall/rise of synchronized cs_b are taken by comparing against a one-cycle delayed copy. The detect is active for exactly one clk.
- FSM states:
  - IDLE: busy=0, miso=0. On a cs_b fall, go to LOAD.
  - LOAD (1 cycle):
    - If tx_valid=1, the shift-out register takes tx_data and tx_ready pulses.
    - If tx_valid=0, it takes DEFAULT_TX and tx_ready stays 0.
    - miso shows the MSB. Bit count clears; busy=1. Go to SHIFT.
  - SHIFT, on sclk rise: shift-in register takes synchronized mosi (MSB first); bit count increments.
  - SHIFT, on sclk rise with count reaching DATA_W:
    - If rx_valid=0 or rx_ready=1 in that cycle, the word is written to rx_data and rx_valid=1 on the next cycle.
    - Otherwise the word is dropped, rx_data is unchanged and overrun is set.
    - Bit count wraps to 0 and the state becomes LOAD_NEXT.
  - SHIFT, on sclk fall: miso advances to the next bit of the shift-out register.
  - LOAD_NEXT: waits for the sclk fall after the last bit. It then performs the LOAD capture rules, presents the new MSB on miso and returns to SHIFT, so back-to-back words need no cs_b toggle.
  - Any state except IDLE, on cs_b rise: go to IDLE; busy=0 next cycle. If bit count is not 0 in SHIFT, pulse frame_err and discard the partial word.
- Simultaneous events:
  - cs_b rise and sclk rise in the same cycle: cs_b wins and no bit is sampled.
  - rx_ready together with a new word completing: the new word is accepted (no overrun).
- rx handshake:
  - rx_valid drops on the cycle after rx_valid and rx_ready are both high, unless a new word lands in that same cycle; in that case it stays high with the new data.
  - rx_data is stable while rx_valid=1.
- overrun clears only on reset.
- Latency:
  - rx_valid rises 1 clk after the cycle that detects the final sclk rise.
  - The sclk-pin-to-detect delay is SYNC_STAGES+1 clk.
- miso is always driven (no tristate); single-slave bus only.

Optional Feature:
- Macro: SPI_SLAVE_CORE_LSB_FIRST_EN.
- When defined: receive and transmit both run LSB-first. Bit 0 is presented at LOAD, and mosi enters at the MSB end, shifting toward bit 0.
- When undefined: MSB-first as above.
- All handshake, timing and error behaviour is identical in both builds.

Test Plan:
- Single frame: tx_valid=1, tx_data=8'hA5; master sends 8'h3C. Required: rx_data=8'h3C with one rx_valid assertion; master receives 8'hA5; tx_ready pulses once.
- No tx word: tx_valid=0; master sends 8'h81. Required: master receives 8'hFF (DEFAULT_TX); rx_data=8'h81; tx_ready never asserted.
- Back-to-back frame: master sends 8'h12 then 8'h34 under one cs_b low; rx_ready held 1; tx words 8'hC0 then 8'hDE. Required: rx words 12 then 34; master receives C0 then DE; frame_err=0.
- Overrun: rx_ready=0; master sends 8'h11 then 8'h22. Required: rx_data stays 8'h11; overrun=1 after the second word; overrun stays 1 after rx_ready is raised.
- Abort: cs_b deasserted after 5 bits of 8'hF0. Required: frame_err pulses once; rx_valid stays 0; busy=0; the next full frame of 8'h5A is received correctly.
- Reset mid-frame: rst_b low for 2 clk during bit 3, with cs_b held low. Required: all outputs 0; no word decoded until cs_b goes high then low again. LSB_FIRST_EN build only: 8'h01 sent LSB-first decodes as 8'h01.
